dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder for the five-stage pipelined core: the target side of the MEM-stage load/store access. It accepts one load or store per request, applies RISC-V byte, half and word sizing from funct3, and returns sign- or zero-extended read data after a programmable number of wait states. While an access is in flight it raises a stall toward the pipeline.

## Interface
Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words of storage; must be a power of two.
- WAIT_STATES, 0: extra cycles inserted between request acceptance and response; range 0–15.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset; synchronous, active-low (0 = reset).
- req_valid  in  1  access request from the MEM stage.
- req_write  in  1  1 = store, 0 = load.
- req_funct3  in  3  access size/sign (RV32I load/store funct3).
- req_addr  in  32  byte address (ALU result).
- req_wdata  in  32  store data; the low byte or halfword is used for SB/SH.
- req_ready  out  1  responder can accept a request this cycle.
- rsp_valid  out  1  one-cycle pulse: access complete.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_error  out  1  qualifies rsp_valid: misaligned access or illegal funct3.
- stall  out  1  hold the pipeline; access not yet complete.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready=1.
  - On req_valid, latch write, funct3, addr and wdata.
  - Go to WAIT (count=WAIT_STATES−1) if WAIT_STATES>0; otherwise go to RESP.
- WAIT: req_ready=0. Decrement the counter each cycle; move to RESP when the counter is 0 at the edge.
- RESP: rsp_valid=1 for exactly one cycle, then return to IDLE. No request is accepted in RESP.
- Word index is addr[log2(DEPTH_WORDS)+1:2]. Higher address bits are ignored, so addresses alias modulo 4·DEPTH_WORDS.
- Loads by funct3:
  - 000 LB: sign-extend the byte at addr[1:0].
  - 001 LH: sign-extend the halfword at addr[1].
  - 010 LW: full word.
  - 100 LBU / 101 LHU: zero-extend.
- Stores by funct3:
  - 000 SB: write one byte lane.
  - 001 SH: write two byte lanes.
  - 010 SW: write all four byte lanes.
  - Lanes that are not enabled keep their old value.
- Error cases:
  - Misaligned: halfword with addr[0]=1, or word with addr[1:0]≠0.
  - Illegal funct3: 011, 110, 111, or 100/101 on a store.
  - On error: no memory write, rsp_error=1, rsp_rdata=0.
- stall = (IDLE ∧ req_valid) ∨ WAIT. stall is 0 in RESP, so the pipeline advances on the edge that ends RESP.

## Timing
- Reset: state=IDLE, counter=0, rsp_valid=0, rsp_rdata=0, rsp_error=0, so req_ready=1 and stall=0. Storage contents are not reset.
- Latency: rsp_valid is asserted WAIT_STATES+1 cycles after the acceptance edge. Throughput is one access per WAIT_STATES+2 cycles.
- Load data is read from storage on entry to RESP and is registered, so it is stable for the RESP cycle.
- Store data commits at the edge that ends RESP. A load accepted immediately afterward sees the new value.
- Request inputs are ignored outside IDLE. Changes after acceptance have no effect.
- rsp_rdata and rsp_error hold their last values outside RESP; they are meaningful only with rsp_valid.
- Reset asserted in WAIT or RESP: the FSM returns to IDLE, a pending store is dropped (no write), and no rsp_valid is issued.
- A back-to-back request held high through RESP is accepted in the following IDLE cycle.

## Structure
- Shared package dmem_pkg:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - FSM state enum {IDLE, WAIT, RESP}.
- Sub-module dmem_lane_align, combinational. From funct3, addr[1:0] and the data inputs it produces:
  - the 4-bit byte-enable and the replicated store word;
  - the extended load result;
  - the error flag.
- The top level holds the FSM, the wait counter, the latched request and the storage array.

## Test plan
- WAIT_STATES=0: SW 0xDEADBEEF @0x10, then LW @0x10 → rsp_valid 1 cycle after acceptance, rdata=0xDEADBEEF, error=0.
- SB 0x80 @0x11, then LB @0x11 → 0xFFFFFF80; LBU @0x11 → 0x00000080; LW @0x10 → 0xDEAD80EF.
- WAIT_STATES=3: LW → stall high for 4 cycles, rsp_valid exactly 4 cycles after acceptance, req_ready=0 throughout.
- LH @0x13, SW @0x12, funct3=011 → rsp_error=1, rdata=0, and a following LW @0x10 shows memory unchanged.
- WAIT_STATES=3: SW 0x12345678 @0x20, rst=0 in the second WAIT cycle → no rsp_valid, outputs at reset values; LW @0x20 then returns the prior contents.
- LW @0x10 + 4·DEPTH_WORDS → same data as @0x10 (aliasing).

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: RV32I load/store funct3
// encodings and the access FSM state type.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: store byte enables and replication, load
// selection with sign/zero extension, and misalignment / illegal-funct3 detection.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic        isWrite,
  input  logic [1:0]  addrLo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byteEn,
  output logic [31:0] storeWord,
  output logic [31:0] loadData,
  output logic        error
);

  logic [7:0]  selByte;
  logic [15:0] selHalf;

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves one unassigned and infers a latch.
    error     = 1'b0;
    byteEn    = 4'b0000;
    storeWord = wdata;
    loadData  = 32'd0;

    case (addrLo)
      2'd0:    selByte = rword[7:0];
      2'd1:    selByte = rword[15:8];
      2'd2:    selByte = rword[23:16];
      default: selByte = rword[31:24];
    endcase
    selHalf = addrLo[1] ? rword[31:16] : rword[15:0];

    case (funct3)
      F3_B: begin
        storeWord = {4{wdata[7:0]}};
        byteEn    = 4'b0001 << addrLo;
        loadData  = {{24{selByte[7]}}, selByte};
      end
      F3_H: begin
        error     = addrLo[0];
        storeWord = {2{wdata[15:0]}};
        byteEn    = addrLo[1] ? 4'b1100 : 4'b0011;
        loadData  = {{16{selHalf[15]}}, selHalf};
      end
      F3_W: begin
        error    = (addrLo != 2'd0);
        byteEn   = 4'b1111;
        loadData = rword;
      end
      F3_BU: begin
        error    = isWrite;
        loadData = {24'd0, selByte};
      end
      F3_HU: begin
        error    = isWrite | addrLo[0];
        loadData = {16'd0, selHalf};
      end
      default: error = 1'b1;
    endcase

    // Errors never write and never return data; stores return zero.
    if (error || !isWrite) byteEn = 4'b0000;
    if (error || isWrite)  loadData = 32'd0;
  end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory target: accepts one load/store, waits WAIT_STATES
// cycles, then pulses a registered response while stalling the pipeline.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic        stall
);

  localparam int         IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t      state;
  logic [3:0]  waitCnt;
  logic        writeQ;
  logic [2:0]  funct3Q;
  logic [31:0] addrQ;
  logic [31:0] wdataQ;

  logic [31:0] mem [DEPTH_WORDS];

  logic             inIdle;
  logic             curWrite;
  logic [2:0]       curFunct3;
  logic [31:0]      curAddr;
  logic [31:0]      curWdata;
  logic [IDX_W-1:0] wordIdx;
  logic [31:0]      rword;
  logic [3:0]       byteEn;
  logic [31:0]      storeWord;
  logic [31:0]      loadData;
  logic             accessErr;
  logic             enterResp;
  logic             unusedAddrBits;

  // In IDLE the live request is decoded so a zero-wait access can register its
  // load data on the acceptance edge; afterwards the latched copy is used.
  assign inIdle    = (state == IDLE);
  assign curWrite  = inIdle ? req_write  : writeQ;
  assign curFunct3 = inIdle ? req_funct3 : funct3Q;
  assign curAddr   = inIdle ? req_addr   : addrQ;
  assign curWdata  = inIdle ? req_wdata  : wdataQ;

  assign wordIdx        = curAddr[IDX_W+1:2];
  assign rword          = mem[wordIdx];
  assign unusedAddrBits = ^{curAddr[31:IDX_W+2]};

  dmem_lane_align u_align (
    .funct3    (curFunct3),
    .isWrite   (curWrite),
    .addrLo    (curAddr[1:0]),
    .wdata     (curWdata),
    .rword     (rword),
    .byteEn    (byteEn),
    .storeWord (storeWord),
    .loadData  (loadData),
    .error     (accessErr)
  );

  assign enterResp = (inIdle && req_valid && (WAIT_STATES == 0)) ||
                     ((state == WAIT) && (waitCnt == 4'd0));

  assign req_ready = inIdle;
  assign stall     = (inIdle && req_valid) || (state == WAIT);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst) begin
      state     <= IDLE;
      waitCnt   <= 4'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_error <= 1'b0;
      writeQ    <= 1'b0;
      funct3Q   <= 3'd0;
      addrQ     <= 32'd0;
      wdataQ    <= 32'd0;
    end else begin
      rsp_valid <= enterResp;
      if (enterResp) begin
        rsp_rdata <= loadData;
        rsp_error <= accessErr;
      end

      case (state)
        IDLE: if (req_valid) begin
          writeQ  <= req_write;
          funct3Q <= req_funct3;
          addrQ   <= req_addr;
          wdataQ  <= req_wdata;
          if (WAIT_STATES > 0) begin
            state   <= WAIT;
            waitCnt <= WAIT_INIT;
          end else begin
            state <= RESP;
          end
        end
        WAIT: begin
          if (waitCnt == 4'd0) state <= RESP;
          else                 waitCnt <= waitCnt - 4'd1;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Stores commit on the edge that ends RESP; a reset in that cycle drops them.
  // NOTE: storage has no reset; only the control path is cleared, so the array maps to plain RAM.
  always_ff @(posedge clk) begin
    if (rst && (state == RESP)) begin
      for (int i = 0; i < 4; i++) begin
        if (byteEn[i]) mem[wordIdx][8*i +: 8] <= storeWord[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: two responders (0 and 3 wait states) driven by a
// scoreboarded access task against a small reference memory model.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int DEPTH = 64;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        reqValid [2];
  logic        reqWrite [2];
  logic [2:0]  reqF3    [2];
  logic [31:0] reqAddr  [2];
  logic [31:0] reqWdata [2];
  logic        reqReady [2];
  logic        rspValid [2];
  logic [31:0] rspRdata [2];
  logic        rspError [2];
  logic        stall    [2];

  exp_t        sbq[$];
  int          nVectors     = 0;
  int          nMiscompares = 0;
  logic [31:0] lastRdata;
  logic [31:0] model [2][DEPTH];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst(rst),
    .req_valid(reqValid[0]), .req_write(reqWrite[0]), .req_funct3(reqF3[0]),
    .req_addr(reqAddr[0]), .req_wdata(reqWdata[0]), .req_ready(reqReady[0]),
    .rsp_valid(rspValid[0]), .rsp_rdata(rspRdata[0]), .rsp_error(rspError[0]),
    .stall(stall[0])
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .rst(rst),
    .req_valid(reqValid[1]), .req_write(reqWrite[1]), .req_funct3(reqF3[1]),
    .req_addr(reqAddr[1]), .req_wdata(reqWdata[1]), .req_ready(reqReady[1]),
    .rsp_valid(rspValid[1]), .rsp_rdata(rspRdata[1]), .rsp_error(rspError[1]),
    .stall(stall[1])
  );

  function automatic int wsOf(input int u);
    return (u == 0) ? 0 : 3;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nVectors++;
    if (got !== exp) begin
      nMiscompares++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic bit expErr(input bit wr, input logic [2:0] f3, input logic [31:0] a);
    case (f3)
      3'b000:  return 1'b0;
      3'b001:  return a[0];
      3'b010:  return a[1:0] != 2'b00;
      3'b100:  return wr;
      3'b101:  return wr || a[0];
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] mload(input int u, input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    w = model[u][(a >> 2) % DEPTH];
    b = w[8*a[1:0] +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b010:  return w;
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return 32'd0;
    endcase
  endfunction

  task automatic mstore(input int u, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    int idx;
    idx = (a >> 2) % DEPTH;
    case (f3)
      3'b000:  model[u][idx][8*a[1:0] +: 8]  = wd[7:0];
      3'b001:  model[u][idx][16*a[1] +: 16] = wd[15:0];
      3'b010:  model[u][idx]                = wd;
      default: ;
    endcase
  endtask

  // One complete access: push expectation, drive, wait (bounded), pop and compare.
  task automatic access(input int u, input bit wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata);
    exp_t x, y;
    bit   e;
    int   lat, stallCnt;
    bit   readyLow;
    e        = expErr(wr, f3, addr);
    x.rdata  = (e || wr) ? 32'd0 : mload(u, f3, addr);
    x.err    = e;
    sbq.push_back(x);
    readyLow = 1'b1;

    @(negedge clk);
    check("rsp_one_cycle", rspValid[u], 1'b0);
    reqValid[u] = 1'b1; reqWrite[u] = wr; reqF3[u] = f3;
    reqAddr[u]  = addr; reqWdata[u] = wdata;
    #1;
    check("ready_idle", reqReady[u], 1'b1);
    stallCnt = int'(stall[u]);
    @(posedge clk);
    #1;
    // Scramble the request after acceptance; the responder must ignore it.
    reqValid[u] = 1'b0; reqWrite[u] = ~wr; reqAddr[u] = addr ^ 32'h4; reqWdata[u] = ~wdata;

    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!rspValid[u]) begin
        stallCnt += int'(stall[u]);
        if (reqReady[u]) readyLow = 1'b0;
      end
    end while (!rspValid[u] && lat < 40);

    y = sbq.pop_front();
    check("rsp_arrived", rspValid[u], 1'b1);
    if (!rspValid[u]) return;
    lastRdata = rspRdata[u];
    check("rdata", rspRdata[u], y.rdata);
    check("error", rspError[u], y.err);
    check("latency", lat, wsOf(u) + 1);
    check("stall_cycles", stallCnt, wsOf(u) + 1);
    check("ready_low_busy", readyLow, 1'b1);
    check("resp_stall", stall[u], 1'b0);
    check("resp_ready", reqReady[u], 1'b0);
    if (wr && !e) mstore(u, f3, addr, wdata);
  endtask

  logic [2:0] f3s [6];
  bit         sawRsp;

  initial begin
    f3s = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011};
    for (int u = 0; u < 2; u++) begin
      reqValid[u] = 1'b0; reqWrite[u] = 1'b0; reqF3[u] = 3'd0;
      reqAddr[u]  = 32'd0; reqWdata[u] = 32'd0;
    end

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      check("rst_ready", reqReady[u], 1'b1);
      check("rst_stall", stall[u], 1'b0);
      check("rst_rsp_valid", rspValid[u], 1'b0);
      check("rst_rdata", rspRdata[u], 32'd0);
      check("rst_error", rspError[u], 1'b0);
    end
    rst = 1'b1;

    // Zero wait states: word, byte, sign/zero extension
    access(0, 1, F3_W, 32'h10, 32'hDEADBEEF);
    access(0, 0, F3_W, 32'h10, 32'h0);
    check("lw_deadbeef", lastRdata, 32'hDEADBEEF);
    access(0, 1, F3_B, 32'h11, 32'h00000080);
    access(0, 0, F3_B, 32'h11, 32'h0);
    check("lb_sext", lastRdata, 32'hFFFFFF80);
    access(0, 0, F3_BU, 32'h11, 32'h0);
    check("lbu_zext", lastRdata, 32'h00000080);
    access(0, 0, F3_W, 32'h10, 32'h0);
    check("lw_merged", lastRdata, 32'hDEAD80EF);
    access(0, 0, F3_H, 32'h12, 32'h0);
    check("lh_upper", lastRdata, 32'hFFFFDEAD);

    // Error cases leave memory untouched
    access(0, 0, F3_H, 32'h13, 32'h0);
    access(0, 1, F3_W, 32'h12, 32'h11111111);
    access(0, 0, 3'b011, 32'h10, 32'h0);
    access(0, 1, F3_BU, 32'h10, 32'h22222222);
    access(0, 1, F3_H, 32'h11, 32'h3333);
    access(0, 0, F3_W, 32'h10, 32'h0);
    check("lw_after_errors", lastRdata, 32'hDEAD80EF);

    // Aliasing modulo 4*DEPTH bytes
    access(0, 0, F3_W, 32'h10 + 4 * DEPTH, 32'h0);
    check("lw_alias", lastRdata, 32'hDEAD80EF);
    access(0, 0, F3_W, 32'h8000_0010, 32'h0);
    check("lw_alias_high", lastRdata, 32'hDEAD80EF);

    // Randomised mix over a prefilled region
    for (int a = 32'h40; a < 32'h50; a += 4) access(0, 1, F3_W, a, $urandom);
    for (int i = 0; i < 16; i++)
      access(0, bit'($urandom_range(0, 1)), f3s[$urandom_range(0, 5)],
             32'h40 + 32'($urandom_range(0, 15)), $urandom);

    // Three wait states
    access(1, 1, F3_W, 32'h30, 32'hCAFEF00D);
    access(1, 0, F3_W, 32'h30, 32'h0);
    check("ws3_lw", lastRdata, 32'hCAFEF00D);
    access(1, 0, F3_HU, 32'h32, 32'h0);
    check("ws3_lhu", lastRdata, 32'h0000CAFE);

    // Reset in the middle of a pending store drops it
    access(1, 1, F3_W, 32'h20, 32'hA5A5A5A5);
    access(1, 0, F3_W, 32'h20, 32'h0);
    @(negedge clk);
    reqValid[1] = 1'b1; reqWrite[1] = 1'b1; reqF3[1] = F3_W;
    reqAddr[1]  = 32'h20; reqWdata[1] = 32'h12345678;
    @(posedge clk);
    #1;
    reqValid[1] = 1'b0;
    @(negedge clk);
    check("wait1_stall", stall[1], 1'b1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_ready", reqReady[1], 1'b1);
    check("midrst_stall", stall[1], 1'b0);
    check("midrst_rdata", rspRdata[1], 32'd0);
    check("midrst_error", rspError[1], 1'b0);
    sawRsp = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (rspValid[1]) sawRsp = 1'b1;
      @(negedge clk);
    end
    check("midrst_no_rsp", sawRsp, 1'b0);
    access(1, 0, F3_W, 32'h20, 32'h0);
    check("store_dropped", lastRdata, 32'hA5A5A5A5);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
